fifo_rd_arbiter: RTL
====================

# fifo_rd_arbiter

Round-robin arbiter that shares the read port of the async FIFO among `NUM_REQ` consumers in the read clock domain. It issues grants in bounded bursts, drives the FIFO read-increment, and steers read data and a per-consumer valid to the granted consumer. It connects directly to the FIFO read-pointer/empty logic (`r_empty`, `r_inc`) and the memory read data, and lives entirely in the read clock domain.

## Interface
- `NUM_REQ`, 4: number of consumers; must be ≥2.
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum words popped per grant; must be ≥1.
- `STALL_MAX`, 8: consecutive no-pop cycles tolerated in a grant before forced release; must be ≥1.

Ports:
- `r_clk`  in  1  read-domain clock. One clock; all state on its rising edge.
- `r_rst`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  per-consumer read request, level.
- `ready`  in  NUM_REQ  per-consumer accept; a word transfers when the granted consumer has `req` and `ready` high and the FIFO is not empty.
- `r_empty`  in  1  FIFO empty flag. It is registered.
- `r_rdata`  in  DATA_WIDTH  FIFO read data at the current read address.
- `r_inc`  out  1  FIFO read increment (pop).
- `gnt`  out  NUM_REQ  one-hot grant, registered.
- `out_data`  out  DATA_WIDTH  equals `r_rdata`, shared by all consumers.
- `out_valid`  out  NUM_REQ  equals `gnt & {NUM_REQ{r_inc}}`.
- `busy`  out  1  high while in GRANT.

## Operation
- States:
  - IDLE: `gnt`=0.
  - GRANT: `gnt` is one-hot with index `g`.
- Priority pointer `last`, width `$clog2(NUM_REQ)`. Search order is `last+1`, `last+2`, … modulo `NUM_REQ`.
- **IDLE → GRANT** when any `req` is high and `r_empty`=0.
  - `g` is the first requester in search order.
  - `burst_cnt` and `stall_cnt` are cleared.
  - If `r_empty`=1, stay in IDLE regardless of `req`.
- **Beat in GRANT:** `beat = req[g] & ready[g] & ~r_empty`. `r_inc = beat`, combinational. Outside GRANT, `r_inc` is 0.
- On a beat: `burst_cnt` increments and `stall_cnt` is cleared.
- On no beat with `req[g]` high: `stall_cnt` increments. This covers both `ready` low and FIFO empty.
- **GRANT → IDLE** when any of the following holds. On exit, `last` is set to `g`.
  - `beat` and `burst_cnt == MAX_BURST-1`: burst complete.
  - `req[g]` = 0: consumer withdrew. No pop occurs this cycle.
  - `~beat` and `stall_cnt == STALL_MAX-1`: stall timeout.
- Counter widths:
  - `burst_cnt` is `$clog2(MAX_BURST+1)` bits.
  - `stall_cnt` is `$clog2(STALL_MAX+1)` bits.
  - Neither counter wraps, because exit occurs first.
- Requests from non-granted consumers are ignored until the grant is released. There is no preemption.
- The block never issues `r_inc` while `r_empty`=1. Pop-on-empty is impossible by construction.
- **Reset**, when `r_rst`=1 at a clock edge:
  - State goes to IDLE. `gnt`=0, `burst_cnt`=0, `stall_cnt`=0.
  - `last = NUM_REQ-1`, so consumer 0 has first priority.
  - The registered outputs therefore reset as follows: `gnt`=0 and `busy`=0.
  - The combinational outputs take these values during reset: `r_inc`=0 and `out_valid`=0. `out_data` follows `r_rdata`.
  - Mid-burst reset drops the grant at that edge. Words already popped are not replayed.

## Timing
- Grant latency:
  - IDLE with a qualifying request at cycle t → `gnt` high at t+1.
  - The first pop is possible at t+1 if `ready` is high.
- Throughput within a grant: one word per cycle. A full burst pops `MAX_BURST` words in `MAX_BURST` consecutive cycles.
- Exit condition at cycle t → IDLE at t+1 (`gnt`=0) → the next grant at t+2 at the earliest. There is exactly one bubble cycle between bursts.
- `r_empty` updates one cycle after a pop. Back-to-back pops rely on the FIFO's registered empty computed from the next pointer; the arbiter adds no extra gating.
- Combinational paths: `req`/`ready`/`r_empty` → `r_inc`/`out_valid`. The downstream FIFO registers `r_inc`.

## Test plan
- **Reset, then single consumer.**
  - Stimulus: reset, then FIFO holding 10 words, `req[0]`=`ready[0]`=1.
  - Required response:
    - Grants of 4, 4 and 2 words, with one bubble cycle between grants.
    - The third grant ends by stall timeout 8 cycles after the FIFO empties.
    - All 10 words appear on `out_data` in order with `out_valid[0]`.
- **Round-robin fairness.**
  - Stimulus: `req`=4'b1111 with all `ready` high and a FIFO that never empties.
  - Required response: grant order 0, 1, 2, 3, 0, …, each burst exactly 4 pops.
- **Withdrawal and stall.**
  - Stimulus for withdrawal: consumer 2 granted; drop `req[2]` after 1 pop.
  - Required response: 1 word popped and grant released the next cycle.
  - Stimulus for stall: hold `ready[1]` low for 8 cycles while granted.
  - Required response: release with 0 pops and `last`=1.
- **Empty gating.**
  - Stimulus: assert `req` while `r_empty`=1 for 5 cycles.
  - Required response: `gnt` stays 0 and `r_inc` stays 0.
  - Stimulus: FIFO goes empty mid-burst.
  - Required response: `r_inc` drops the same cycle `r_empty` rises.
- **Reset mid-burst.**
  - Stimulus: assert `r_rst` after 2 pops of a burst.
  - Required response: `gnt`=0 at the next edge, and the next grant after reset goes to consumer 0.
- **Boundary parameters.**
  - Stimulus: `MAX_BURST`=1, `NUM_REQ`=2.
  - Required response: grants strictly alternate, exactly one pop per grant.

Source files
------------

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port among NUM_REQ consumers.
// Grants are issued in bursts of up to MAX_BURST pops, released early on withdrawal or stall.
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int STALL_MAX  = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    ready,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_rdata,
  output logic                  r_inc,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_REQ-1:0]    out_valid,
  output logic                  busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
  localparam logic [PW-1:0] LAST_RST   = PW'(NUM_REQ - 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      idx_q, idx_d;
  logic [PW-1:0]      last_q, last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [SW-1:0]      stall_q, stall_d;

  logic          req_g, rdy_g, beat, done;
  logic [PW-1:0] pick;
  logic          pick_vld;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    rr_idx = PW'((int'(base) + off) % NUM_REQ);
  endfunction

  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[rr_idx(last_q, i)]) begin
        pick     = rr_idx(last_q, i);
        pick_vld = 1'b1;
      end
    end
  end

  assign req_g = req[idx_q];
  assign rdy_g = ready[idx_q];
  assign beat  = (state_q == GRANT) & req_g & rdy_g & ~r_empty & ~r_rst;
  assign done  = ~req_g
               | (beat & (burst_q == BURST_LAST))
               | (~beat & (stall_q == STALL_LAST));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    burst_d = burst_q;
    stall_d = stall_q;
    if (state_q == IDLE) begin
      if (pick_vld && !r_empty) begin
        state_d = GRANT;
        idx_d   = pick;
        gnt_d   = NUM_REQ'(1) << pick;
        burst_d = '0;
        stall_d = '0;
      end
    end else begin
      if (beat) begin
        burst_d = burst_q + 1'b1;
        stall_d = '0;
      end else if (req_g) begin
        stall_d = stall_q + 1'b1;
      end
      if (done) begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = idx_q;
      end
    end
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
      burst_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
    end
  end

  assign r_inc     = beat;
  assign gnt       = gnt_q;
  assign out_data  = r_rdata;
  assign out_valid = gnt_q & {NUM_REQ{beat}};
  assign busy      = (state_q == GRANT);

endmodule
